// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexes three active-low 7-segment codes (hundreds/tens/units) onto
// a common-anode 4-digit display with shared cathodes and active-low anodes.
// Each digit slot is REFRESH_DIV cycles long. The first BLANK_CYCLES cycles of
// a slot keep every anode off to avoid ghosting. Leading-zero blanking is
// optional. The inputs are captured once per frame, so a frame never tears.
//
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (must exceed BLANK_CYCLES)
//   BLANK_CYCLES  dark cycles at the start of each slot (0 = no blank phase)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          1 = scan the display, 0 = display dark
//   seg_1..3    digit codes, active-low {g..a}; seg_1 = hundreds
//   dp_mask     decimal-point request, bit2 = digit1 .. bit0 = digit3, 1 = lit
//   blank_lz    1 = suppress leading zero digits
//   seg         cathode drive, active-low
//   dp          decimal-point cathode, active-low
//   an          anode drive, active-low; an[3] is unused and stays 1
//   digit_idx   slot being scanned (0..2)
//   frame_done  one-cycle pulse on the last cycle of the digit3 slot
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_1,
  input  logic [6:0] seg_2,
  input  logic [6:0] seg_3,
  input  logic [2:0] dp_mask,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [6:0]    ZERO_CODE = 7'b1000000;
  localparam logic [6:0]    SEG_DARK  = 7'h7F;
  localparam logic [3:0]    AN_OFF    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;

  // Per-frame snapshot of the inputs.
  logic [6:0]    snap1_q, snap1_d;
  logic [6:0]    snap2_q, snap2_d;
  logic [6:0]    snap3_q, snap3_d;
  logic [2:0]    snap_dp_q, snap_dp_d;
  logic          snap_lz_q, snap_lz_d;

  // Registered outputs.
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          take_snap;
  logic          lz1, lz2;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    snap1_d   = snap1_q;
    snap2_d   = snap2_q;
    snap3_d   = snap3_q;
    snap_dp_d = snap_dp_q;
    snap_lz_d = snap_lz_q;
    take_snap = 1'b0;
    seg_d     = SEG_DARK;
    dp_d      = 1'b1;
    an_d      = AN_OFF;
    fd_d      = 1'b0;
    lz1       = 1'b0;
    lz2       = 1'b0;

    // Slot sequencing. The counter holds the position inside the current slot.
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      dig_d   = 2'd0;
    end else if (state_q == ST_IDLE) begin
      cnt_d     = '0;
      dig_d     = 2'd0;
      take_snap = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (dig_q == 2'd2) begin
        dig_d     = 2'd0;
        take_snap = 1'b1;   // wrap straight into the next frame
      end else begin
        dig_d = dig_q + 2'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (take_snap) begin
      snap1_d   = seg_1;
      snap2_d   = seg_2;
      snap3_d   = seg_3;
      snap_dp_d = dp_mask;
      snap_lz_d = blank_lz;
    end

    // The blank phase is the first BLANK_CYCLES positions of every slot.
    if (en) begin
      state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end

    // Leading-zero chain: digit2 is only blanked when digit1 is blanked too.
    lz1 = snap_lz_d && (snap1_d == ZERO_CODE);
    lz2 = lz1 && (snap2_d == ZERO_CODE);

    // Outputs follow the state being entered on this edge.
    if (state_d == ST_SHOW) begin
      case (dig_d)
        2'd0: begin
          if (!lz1) begin
            an_d  = 4'b1011;
            seg_d = snap1_d;
            dp_d  = ~snap_dp_d[2];
          end
        end
        2'd1: begin
          if (!lz2) begin
            an_d  = 4'b1101;
            seg_d = snap2_d;
            dp_d  = ~snap_dp_d[1];
          end
        end
        2'd2: begin
          an_d  = 4'b1110;
          seg_d = snap3_d;
          dp_d  = ~snap_dp_d[0];
        end
        default: begin
          an_d = AN_OFF;
        end
      endcase
      fd_d = (dig_d == 2'd2) && (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dig_q     <= 2'd0;
      snap1_q   <= SEG_DARK;
      snap2_q   <= SEG_DARK;
      snap3_q   <= SEG_DARK;
      snap_dp_q <= 3'b000;
      snap_lz_q <= 1'b0;
      seg_q     <= SEG_DARK;
      dp_q      <= 1'b1;
      an_q      <= AN_OFF;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      snap1_q   <= snap1_d;
      snap2_q   <= snap2_d;
      snap3_q   <= snap3_d;
      snap_dp_q <= snap_dp_d;
      snap_lz_q <= snap_lz_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Bench for seg7_scan_driver with REFRESH_DIV=8 and BLANK_CYCLES=2. A table of
// input patterns holds hand-computed per-slot expectations, and each pattern
// is checked cycle by cycle over two frames. Hand-written sequences cover
// async reset, mid-frame input changes, enable drop and re-enable.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [6:0] seg_1 = 7'h7F;
  logic [6:0] seg_2 = 7'h7F;
  logic [6:0] seg_3 = 7'h7F;
  logic [2:0] dp_mask = 3'b000;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seg_1      (seg_1),
    .seg_2      (seg_2),
    .seg_3      (seg_3),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // One input pattern with the expected SHOW-phase outputs of each slot.
  typedef struct {
    string            name;
    logic [6:0]       s1, s2, s3;
    logic [2:0]       dpm;
    logic             lz;
    logic [2:0][3:0]  an;
    logic [2:0][6:0]  sg;
    logic [2:0]       dpx;   // indexed by slot
  } vec_t;

  function automatic vec_t mk(input string name,
                              input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                              input logic [2:0] dpm, input logic lz,
                              input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                              input logic [6:0] q0, input logic [6:0] q1, input logic [6:0] q2,
                              input logic [2:0] dpx);
    vec_t v;
    v.name = name;
    v.s1 = s1; v.s2 = s2; v.s3 = s3;
    v.dpm = dpm; v.lz = lz;
    v.an = {a2, a1, a0};
    v.sg = {q2, q1, q0};
    v.dpx = dpx;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input logic [1:0] e_idx, input logic e_fd);
    n_cmp++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || digit_idx !== e_idx || frame_done !== e_fd) begin
      n_bad++;
      $display("FAIL %s @%0t: got an=%b seg=%b dp=%b idx=%0d fd=%b, want an=%b seg=%b dp=%b idx=%0d fd=%b",
               name, $time, an, seg, dp, digit_idx, frame_done, e_an, e_seg, e_dp, e_idx, e_fd);
    end
  endtask

  // Slot k, position c: dark for the blank phase, else the SHOW values.
  task automatic check_cycle(input string name, input int k, input int c,
                             input logic [3:0] s_an, input logic [6:0] s_seg, input logic s_dp);
    if (c < BLK)
      check(name, 4'b1111, 7'h7F, 1'b1, 2'(k), 1'b0);
    else
      check(name, s_an, s_seg, s_dp, 2'(k), (k == 2 && c == DIV - 1));
  endtask

  task automatic apply(input vec_t v);
    seg_1 = v.s1; seg_2 = v.s2; seg_3 = v.s3;
    dp_mask = v.dpm; blank_lz = v.lz;
  endtask

  task automatic run_frames(input vec_t v, input int nf);
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < DIV; c++) begin
          @(negedge clk);
          check_cycle(v.name, k, c, v.an[k], v.sg[k], v.dpx[k]);
        end
  endtask

  // Called at a negedge: drop en and confirm the idle state one edge later.
  task automatic go_idle(input string name);
    en = 1'b0;
    @(negedge clk);
    check(name, 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mk("scan", 7'b1111001, 7'b0100100, 7'b0110000, 3'b000, 1'b0,
                 4'b1011, 4'b1101, 4'b1110, 7'b1111001, 7'b0100100, 7'b0110000, 3'b111);
    vecs[1] = mk("lz_both", 7'b1000000, 7'b1000000, 7'b0010010, 3'b000, 1'b1,
                 4'b1111, 4'b1111, 4'b1110, 7'h7F, 7'h7F, 7'b0010010, 3'b111);
    vecs[2] = mk("lz_first", 7'b1000000, 7'b1111001, 7'b0010010, 3'b000, 1'b1,
                 4'b1111, 4'b1101, 4'b1110, 7'h7F, 7'b1111001, 7'b0010010, 3'b111);
    vecs[3] = mk("dp_mid", 7'b1111001, 7'b0100100, 7'b0110000, 3'b010, 1'b0,
                 4'b1011, 4'b1101, 4'b1110, 7'b1111001, 7'b0100100, 7'b0110000, 3'b101);
    vecs[4] = mk("zeros_no_lz", 7'b1000000, 7'b1000000, 7'b1000000, 3'b000, 1'b0,
                 4'b1011, 4'b1101, 4'b1110, 7'b1000000, 7'b1000000, 7'b1000000, 3'b111);
    vecs[5] = mk("lz_mid_zero_err", 7'b1111001, 7'b1000000, 7'h7F, 3'b101, 1'b1,
                 4'b1011, 4'b1101, 4'b1110, 7'b1111001, 7'b1000000, 7'h7F, 3'b010);

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 check("reset", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_en0", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);

    // Table-driven patterns, two frames each to cover the wrap.
    for (int i = 0; i < 6; i++) begin
      go_idle({vecs[i].name, "_idle"});
      apply(vecs[i]);
      en = 1'b1;
      run_frames(vecs[i], 2);
      $display("vector %0d %s: done, %0d compared / %0d bad so far", i, vecs[i].name, n_cmp, n_bad);
    end

    // Mid-frame input change is held until the next frame.
    go_idle("tear_idle");
    apply(vecs[0]);
    en = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < DIV; c++) begin
          @(negedge clk);
          if (k == 2)
            check_cycle("tear", k, c, 4'b1110, (f == 0) ? 7'b0110000 : 7'b1111000, 1'b1);
          else
            check_cycle("tear", k, c, vecs[0].an[k], vecs[0].sg[k], 1'b1);
          if (f == 0 && k == 0 && c == 4) seg_3 = 7'b1111000;
        end
    $display("sequence tear: done, %0d compared / %0d bad so far", n_cmp, n_bad);

    // Enable drop during digit2 SHOW, then restart with a fresh snapshot.
    go_idle("endrop_idle");
    apply(vecs[0]);
    en = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < DIV; c++) begin
        if (k == 1 && c == 4) break;
        @(negedge clk);
        check_cycle("endrop_pre", k, c, vecs[0].an[k], vecs[0].sg[k], 1'b1);
      end
    en = 1'b0;
    @(negedge clk);
    check("endrop_dark", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("endrop_hold", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    end
    seg_1 = 7'b0110000;
    en = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        check_cycle("enrise", k, c, vecs[0].an[k],
                    (k == 0) ? 7'b0110000 : vecs[0].sg[k], 1'b1);
      end
    $display("sequence enable: done, %0d compared / %0d bad so far", n_cmp, n_bad);

    // Async reset mid-SHOW takes effect before the next clock edge.
    go_idle("rst_idle");
    apply(vecs[0]);
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_cycle("rst_pre", 0, c, 4'b1011, 7'b1111001, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 check("rst_async", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    check("rst_held", 4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0);
    rst_n = 1'b1;
    run_frames(vecs[0], 1);
    $display("sequence reset: done, %0d compared / %0d bad so far", n_cmp, n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
